fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter data_size, default 32, as the width of addresses and instructions.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port PC_in, input, data_size, the current fetch address from the program counter.
REQ-005 SHALL have port pc_hold, output, 1; high holds the program counter, low lets it advance; drives the counter's enable directly.
REQ-006 SHALL have port imem_req, output, 1, the instruction-memory read request.
REQ-007 SHALL have port imem_addr, output, data_size, the request address.
REQ-008 SHALL have port imem_gnt, input, 1, memory accepts the request this cycle.
REQ-009 SHALL have port imem_rvalid, input, 1, read data valid.
REQ-010 SHALL have port imem_rdata, input, data_size, the instruction word.
REQ-011 SHALL have port flush, input, 1, discard all fetched and in-flight instructions.
REQ-012 SHALL have port IF_valid, output, 1, queue head is valid.
REQ-013 SHALL have port IF_instr, output, data_size, queue head instruction.
REQ-014 SHALL have port IF_pc_plus4, output, data_size, queue head address + 4.
REQ-015 SHALL have port ID_ready, input, 1, decode consumes the head when high with IF_valid.

Function
REQ-016 SHALL hold a 2-entry FIFO of {address, instruction}, with occupancy count 0..2.
REQ-017 SHALL run FSM IDLE (no request outstanding), WAIT (one outstanding), DROP (outstanding response to discard).
REQ-018 SHALL assert imem_req combinationally when state is IDLE, count < 2, and flush is low; imem_addr SHALL equal PC_in.
REQ-019 SHALL drive pc_hold = NOT (imem_req AND imem_gnt); PC advances exactly once per accepted request.
REQ-020 On accept, IDLE SHALL go to WAIT and register imem_addr as the in-flight address.
REQ-021 In WAIT with imem_rvalid, SHALL push {in-flight address, imem_rdata} and return to IDLE; response latency is unbounded, with at most one request outstanding.
REQ-022 SHALL raise IF_valid when count > 0; pop SHALL occur when IF_valid AND ID_ready.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 A push SHALL never occur with count 2; the request gating in REQ-018 guarantees this, and the bench SHALL assert it.
REQ-025 IF_pc_plus4 SHALL be head address + 4 modulo 2^data_size; 0xFFFFFFFC yields 0x00000000.
REQ-026 flush SHALL empty the FIFO at the next edge, dropping any same-cycle pop and push.
REQ-027 flush in WAIT without rvalid SHALL go to DROP; flush in WAIT with rvalid SHALL go to IDLE, data discarded.
REQ-028 In DROP, rvalid SHALL be discarded and the FSM SHALL go to IDLE; imem_req SHALL stay low in DROP.
REQ-029 flush in IDLE SHALL suppress imem_req that cycle, so pc_hold is high.
REQ-030 When IF_valid is low, IF_instr and IF_pc_plus4 are don't-care.

Reset
REQ-031 reset low SHALL immediately force: state IDLE, count 0, IF_valid 0, imem_req 0, pc_hold 1, stored entries and in-flight address 0.
REQ-032 A response arriving after reset release for a request issued before reset SHALL NOT occur; memory is reset by the same signal.
REQ-033 First request SHALL be issued in the first cycle after reset deasserts, at PC_in.

Configuration
REQ-034 With macro FETCH_PERF_CNT_EN defined, SHALL add output stall_cnt (32 bits), reset to 0, incrementing by one each cycle pc_hold is high with reset released, wrapping at 2^32.
REQ-035 Without FETCH_PERF_CNT_EN, stall_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Gnt always 1, rvalid 1 cycle after request, ID_ready 1, PC_in 0,4,8 -> IF_instr sequence matches memory in order, IF_pc_plus4 4,8,12, one request every two cycles.
REQ-037 ID_ready held 0 -> after two pushes, count 2, imem_req 0, pc_hold 1 steady; ID_ready 1 for one cycle -> one pop, next request issued.
REQ-038 Request at 0x40 accepted, flush before rvalid, rvalid 3 cycles later -> DROP entered, data discarded, IF_valid 0, next request only after DROP exit.
REQ-039 flush in the same cycle as rvalid with count 1 -> FIFO empty next cycle, state IDLE.
REQ-040 Head address 0xFFFFFFFC -> IF_pc_plus4 = 0x00000000.
REQ-041 reset pulsed low mid-WAIT with count 2 -> outputs reach the REQ-031 values asynchronously; with FETCH_PERF_CNT_EN, stall_cnt = 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one memory read at a time from the program
// counter address and buffers returned instructions in a 2-entry queue that
// feeds decode. A flush empties the queue and discards any response still
// in flight.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the 32-bit stall_cnt
// output, which counts the cycles in which the program counter is held.

module fetch_stage #(
    parameter int data_size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [data_size-1:0] PC_in,
    output logic                 pc_hold,
    output logic                 imem_req,
    output logic [data_size-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [data_size-1:0] imem_rdata,
    input  logic                 flush,
    output logic                 IF_valid,
    output logic [data_size-1:0] IF_instr,
    output logic [data_size-1:0] IF_pc_plus4,
    input  logic                 ID_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [1:0]           count;
    logic [data_size-1:0] inflight_addr;
    logic [data_size-1:0] fifo_addr  [2];
    logic [data_size-1:0] fifo_instr [2];
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 wr_idx;

    // Handshake and queue control; reset gates the request so the PC holds
    always_comb begin
        imem_req  = reset && (state == IDLE) && (count < 2'd2) && !flush;
        imem_addr = PC_in;
        accept    = imem_req && imem_gnt;
        pc_hold   = !accept;
        IF_valid  = (count != 2'd0);
        push      = (state == WAIT) && imem_rvalid && !flush;
        pop       = IF_valid && ID_ready && !flush;
        wr_idx    = (count == 2'd2) || ((count == 2'd1) && !pop);
    end

    // Queue head is always entry 0
    always_comb begin
        IF_instr    = fifo_instr[0];
        IF_pc_plus4 = fifo_addr[0] + data_size'(4);
    end

    // Fetch FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a flush before the response arrives must swallow it in DROP
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Remember the address of the outstanding request for tagging its response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_addr <= '0;
        end else if (accept) begin
            inflight_addr <= PC_in;
        end
    end

    // Shift-on-pop queue; a push lands behind whatever survives the pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count         <= 2'd0;
            fifo_addr[0]  <= '0;
            fifo_addr[1]  <= '0;
            fifo_instr[0] <= '0;
            fifo_instr[1] <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                fifo_addr[0]  <= fifo_addr[1];
                fifo_instr[0] <= fifo_instr[1];
            end
            if (push) begin
                fifo_addr[wr_idx]  <= inflight_addr;
                fifo_instr[wr_idx] <= imem_rdata;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count every cycle in which the program counter is held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 32'd0;
        end else if (pc_hold) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
